// File: rtl/atm_pkg.sv
// Shared constants, types and initial account table for the ATM account ledger.
package atm_pkg;

   localparam int unsigned NUM_ACCOUNTS = 10;
   localparam int unsigned ACC_W        = 12;
   localparam int unsigned PIN_W        = 4;
   localparam int unsigned BAL_W        = 11;
   localparam int unsigned IDX_W        = $clog2(NUM_ACCOUNTS);

   localparam logic [2:0] MENU_FIND                  = 3'b000;
   localparam logic [2:0] MENU_RSVD1                 = 3'b001;
   localparam logic [2:0] MENU_RSVD2                 = 3'b010;
   localparam logic [2:0] MENU_BALANCE               = 3'b011;
   localparam logic [2:0] MENU_WITHDRAW              = 3'b100;
   localparam logic [2:0] MENU_WITHDRAW_SHOW_BALANCE = 3'b101;
   localparam logic [2:0] MENU_TRANSACTION           = 3'b110;
   localparam logic [2:0] MENU_DEPOSIT               = 3'b111;

   typedef enum logic [2:0] {
      OK             = 3'd0,
      NOT_FOUND      = 3'd1,
      BAD_PIN        = 3'd2,
      INSUFFICIENT   = 3'd3,
      OVERFLOW       = 3'd4,
      DEST_NOT_FOUND = 3'd5,
      SAME_ACCOUNT   = 3'd6,
      BAD_OP         = 3'd7
   } status_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SCAN_SRC = 3'd1,
      SCAN_DST = 3'd2,
      EXEC     = 3'd3,
      RESP     = 3'd4
   } state_t;

   localparam logic [ACC_W-1:0] ACC_INIT [NUM_ACCOUNTS] = '{
      12'd2178, 12'd1111, 12'd1222, 12'd1333, 12'd1444,
      12'd2429, 12'd1555, 12'd1666, 12'd1777, 12'd3000
   };

   localparam logic [PIN_W-1:0] PIN_INIT [NUM_ACCOUNTS] = '{
      4'd4, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd5, 4'd6, 4'd7, 4'd1
   };

   localparam logic [BAL_W-1:0] BAL_INIT [NUM_ACCOUNTS] = '{
      11'd500, 11'd100, 11'd200, 11'd300, 11'd400,
      11'd1000, 11'd600, 11'd700, 11'd800, 11'd2047
   };

endpackage

// File: rtl/account_scanner.sv
// Sequential table scanner: walks the account numbers one entry per cycle and flags a match.
module account_scanner
   import atm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             step,
   input  logic [ACC_W-1:0] key,
   output logic [IDX_W-1:0] idx,
   output logic             hit_c,
   output logic             last_c
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         idx <= '0;
      end else if (step) begin
         idx <= idx + IDX_W'(1);
      end
   end

   // Scanning upward from zero makes the lowest matching index win.
   assign hit_c  = (ACC_INIT[idx] == key);
   assign last_c = (idx == IDX_W'(NUM_ACCOUNTS - 1));

endmodule

// File: rtl/account_ledger.sv
// Bank-side account store: scans, authenticates and applies one transaction per request.
module account_ledger
   import atm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             reqValid,
   output logic             reqReady,
   input  logic [ACC_W-1:0] accNumber,
   input  logic [PIN_W-1:0] pin,
   input  logic [ACC_W-1:0] destinationAccNumber,
   input  logic [2:0]       menuOption,
   input  logic [BAL_W-1:0] amount,
   output logic             respValid,
   output logic [2:0]       respCode,
   output logic             error,
   output logic [BAL_W-1:0] balance
);

   state_t           state;
   logic [BAL_W-1:0] bal_q [NUM_ACCOUNTS];

   logic [ACC_W-1:0] lat_acc;
   logic [PIN_W-1:0] lat_pin;
   logic [ACC_W-1:0] lat_dst;
   logic [2:0]       lat_op;
   logic [BAL_W-1:0] lat_amount;
   logic [IDX_W-1:0] src_idx;
   logic [IDX_W-1:0] dst_idx;

   logic             scan_c;
   logic             clear_c;
   logic             step_c;
   logic [ACC_W-1:0] key_c;
   logic [IDX_W-1:0] idx;
   logic             hit_c;
   logic             last_c;

   // One scanner serves both lookups; the key follows the scan phase.
   assign scan_c  = (state == SCAN_SRC) || (state == SCAN_DST);
   assign clear_c = (state == IDLE) || ((state == SCAN_SRC) && hit_c);
   assign step_c  = scan_c && !hit_c && !last_c;
   assign key_c   = (state == SCAN_DST) ? lat_dst : lat_acc;

   account_scanner u_scanner (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear_c),
      .step   (step_c),
      .key    (key_c),
      .idx    (idx),
      .hit_c  (hit_c),
      .last_c (last_c)
   );

   logic [BAL_W-1:0] src_bal_c;
   logic [BAL_W-1:0] dst_bal_c;
   logic [BAL_W:0]   src_sum_c;
   logic [BAL_W:0]   dst_sum_c;
   status_t          exec_code_c;
   logic [BAL_W-1:0] new_src_c;
   logic [BAL_W-1:0] new_dst_c;
   logic             wr_src_c;
   logic             wr_dst_c;

   // Execution checks in priority order; sums carry one extra bit so they never wrap.
   always_comb begin
      src_bal_c   = bal_q[src_idx];
      dst_bal_c   = bal_q[dst_idx];
      src_sum_c   = {1'b0, src_bal_c} + {1'b0, lat_amount};
      dst_sum_c   = {1'b0, dst_bal_c} + {1'b0, lat_amount};
      exec_code_c = OK;
      new_src_c   = src_bal_c;
      new_dst_c   = dst_bal_c;
      wr_src_c    = 1'b0;
      wr_dst_c    = 1'b0;
      if (lat_op == MENU_FIND) begin
         exec_code_c = OK;
      end else if ((lat_op == MENU_RSVD1) || (lat_op == MENU_RSVD2)) begin
         exec_code_c = BAD_OP;
      end else if (lat_pin != PIN_INIT[src_idx]) begin
         exec_code_c = BAD_PIN;
      end else begin
         case (lat_op)
            MENU_WITHDRAW, MENU_WITHDRAW_SHOW_BALANCE: begin
               if (lat_amount > src_bal_c) begin
                  exec_code_c = INSUFFICIENT;
               end else begin
                  new_src_c = src_bal_c - lat_amount;
                  wr_src_c  = 1'b1;
               end
            end
            MENU_DEPOSIT: begin
               if (src_sum_c[BAL_W]) begin
                  exec_code_c = OVERFLOW;
               end else begin
                  new_src_c = src_sum_c[BAL_W-1:0];
                  wr_src_c  = 1'b1;
               end
            end
            MENU_TRANSACTION: begin
               if (src_idx == dst_idx) begin
                  exec_code_c = SAME_ACCOUNT;
               end else if (lat_amount > src_bal_c) begin
                  exec_code_c = INSUFFICIENT;
               end else if (dst_sum_c[BAL_W]) begin
                  exec_code_c = OVERFLOW;
               end else begin
                  new_src_c = src_bal_c - lat_amount;
                  new_dst_c = dst_sum_c[BAL_W-1:0];
                  wr_src_c  = 1'b1;
                  wr_dst_c  = 1'b1;
               end
            end
            default: begin
               exec_code_c = OK;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         reqReady   <= 1'b1;
         respValid  <= 1'b0;
         respCode   <= OK;
         error      <= 1'b0;
         balance    <= '0;
         lat_acc    <= '0;
         lat_pin    <= '0;
         lat_dst    <= '0;
         lat_op     <= '0;
         lat_amount <= '0;
         src_idx    <= '0;
         dst_idx    <= '0;
         for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            bal_q[i] <= BAL_INIT[i];
         end
      end else begin
         respValid <= 1'b0;
         case (state)
            IDLE: begin
               if (reqValid) begin
                  lat_acc    <= accNumber;
                  lat_pin    <= pin;
                  lat_dst    <= destinationAccNumber;
                  lat_op     <= menuOption;
                  lat_amount <= amount;
                  reqReady   <= 1'b0;
                  state      <= SCAN_SRC;
               end
            end
            SCAN_SRC: begin
               if (hit_c) begin
                  src_idx <= idx;
                  state   <= (lat_op == MENU_TRANSACTION) ? SCAN_DST : EXEC;
               end else if (last_c) begin
                  respValid <= 1'b1;
                  respCode  <= NOT_FOUND;
                  error     <= 1'b1;
                  balance   <= '0;
                  state     <= RESP;
               end
            end
            SCAN_DST: begin
               if (hit_c) begin
                  dst_idx <= idx;
                  state   <= EXEC;
               end else if (last_c) begin
                  respValid <= 1'b1;
                  respCode  <= DEST_NOT_FOUND;
                  error     <= 1'b1;
                  balance   <= '0;
                  state     <= RESP;
               end
            end
            EXEC: begin
               if (wr_src_c) bal_q[src_idx] <= new_src_c;
               if (wr_dst_c) bal_q[dst_idx] <= new_dst_c;
               respValid <= 1'b1;
               respCode  <= exec_code_c;
               error     <= (exec_code_c != OK);
               balance   <= (exec_code_c == OK) ? new_src_c : '0;
               state     <= RESP;
            end
            RESP: begin
               reqReady <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               reqReady <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_account_ledger.sv
// Directed vector bench for account_ledger: response codes, balances and latencies.
module tb_account_ledger;

   logic        clk;
   logic        rst;
   logic        reqValid;
   logic        reqReady;
   logic [11:0] accNumber;
   logic [3:0]  pin;
   logic [11:0] destinationAccNumber;
   logic [2:0]  menuOption;
   logic [10:0] amount;
   logic        respValid;
   logic [2:0]  respCode;
   logic        error;
   logic [10:0] balance;

   int total;
   int bad;

   account_ledger dut (
      .clk                  (clk),
      .rst                  (rst),
      .reqValid             (reqValid),
      .reqReady             (reqReady),
      .accNumber            (accNumber),
      .pin                  (pin),
      .destinationAccNumber (destinationAccNumber),
      .menuOption           (menuOption),
      .amount               (amount),
      .respValid            (respValid),
      .respCode             (respCode),
      .error                (error),
      .balance              (balance)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst_first;
      logic [11:0] acc;
      logic [3:0]  pin;
      logic [11:0] dst;
      logic [2:0]  op;
      logic [10:0] amt;
      logic [2:0]  code;
      logic [10:0] bal;
      int          lat;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_reqReady", int'(reqReady), 1);
      check("rst_respValid", int'(respValid), 0);
      check("rst_respCode", int'(respCode), 0);
      check("rst_error", int'(error), 0);
      check("rst_balance", int'(balance), 0);
   endtask

   // Issues one request and returns the edge index after which respValid rose (-1 on timeout).
   task automatic issue(input logic [11:0] a, input logic [3:0] p, input logic [11:0] d,
                        input logic [2:0] op, input logic [10:0] amt, output int lat);
      int n;
      n = 0;
      while (!reqReady && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("wait_ready", int'(reqReady), 1);
      accNumber            = a;
      pin                  = p;
      destinationAccNumber = d;
      menuOption           = op;
      amount               = amt;
      reqValid             = 1'b1;
      @(posedge clk);
      #1;
      reqValid             = 1'b0;
      accNumber            = 12'd0;
      pin                  = 4'd15;
      destinationAccNumber = 12'd0;
      menuOption           = 3'b001;
      amount               = 11'd2047;
      check("busy_reqReady", int'(reqReady), 0);
      lat = 0;
      while (!respValid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!respValid) lat = -1;
   endtask

   initial begin
      int lat;
      int pulses;
      logic [2:0]  held_code;
      logic [10:0] held_bal;
      total = 0;
      bad   = 0;
      rst = 1'b1;
      reqValid = 1'b0;
      accNumber = '0;
      pin = '0;
      destinationAccNumber = '0;
      menuOption = '0;
      amount = '0;

      //          rst   acc       pin   dst       op      amt        code  bal        lat
      vecs[0]  = '{1'b1, 12'd2178, 4'd4, 12'd0,    3'b011, 11'd0,    3'd0, 11'd500,  2};
      vecs[1]  = '{1'b0, 12'd2178, 4'd4, 12'd0,    3'b100, 11'd200,  3'd0, 11'd300,  2};
      vecs[2]  = '{1'b0, 12'd2178, 4'd4, 12'd0,    3'b100, 11'd301,  3'd3, 11'd0,    2};
      vecs[3]  = '{1'b0, 12'd2178, 4'd4, 12'd0,    3'b011, 11'd0,    3'd0, 11'd300,  2};
      vecs[4]  = '{1'b0, 12'd3000, 4'd1, 12'd0,    3'b111, 11'd1,    3'd4, 11'd0,    11};
      vecs[5]  = '{1'b0, 12'd3000, 4'd1, 12'd0,    3'b111, 11'd0,    3'd0, 11'd2047, 11};
      vecs[6]  = '{1'b0, 12'd3000, 4'd1, 12'd0,    3'b011, 11'd0,    3'd0, 11'd2047, 11};
      vecs[7]  = '{1'b1, 12'd2178, 4'd4, 12'd2429, 3'b110, 11'd100,  3'd0, 11'd400,  8};
      vecs[8]  = '{1'b0, 12'd2429, 4'd9, 12'd0,    3'b011, 11'd0,    3'd0, 11'd1100, 7};
      vecs[9]  = '{1'b0, 12'd1234, 4'd0, 12'd0,    3'b000, 11'd0,    3'd1, 11'd0,    10};
      vecs[10] = '{1'b0, 12'd2178, 4'd5, 12'd0,    3'b011, 11'd0,    3'd2, 11'd0,    2};
      vecs[11] = '{1'b0, 12'd2178, 4'd4, 12'd2178, 3'b110, 11'd10,   3'd6, 11'd0,    3};
      vecs[12] = '{1'b0, 12'd2178, 4'd4, 12'd0,    3'b010, 11'd0,    3'd7, 11'd0,    2};
      vecs[13] = '{1'b0, 12'd2429, 4'd0, 12'd0,    3'b000, 11'd0,    3'd0, 11'd1100, 7};
      vecs[14] = '{1'b0, 12'd2178, 4'd4, 12'd999,  3'b110, 11'd1,    3'd5, 11'd0,    11};
      vecs[15] = '{1'b0, 12'd2178, 4'd4, 12'd0,    3'b101, 11'd400,  3'd0, 11'd0,    2};
      vecs[16] = '{1'b0, 12'd2429, 4'd9, 12'd3000, 3'b110, 11'd1,    3'd4, 11'd0,    17};
      vecs[17] = '{1'b0, 12'd2429, 4'd9, 12'd2178, 3'b110, 11'd1101, 3'd3, 11'd0,    8};
      vecs[18] = '{1'b0, 12'd2429, 4'd9, 12'd0,    3'b111, 11'd947,  3'd0, 11'd2047, 7};
      vecs[19] = '{1'b0, 12'd1234, 4'd0, 12'd0,    3'b001, 11'd0,    3'd1, 11'd0,    10};

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].rst_first) do_reset();
         issue(vecs[i].acc, vecs[i].pin, vecs[i].dst, vecs[i].op, vecs[i].amt, lat);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_code", i), int'(respCode), int'(vecs[i].code));
         check($sformatf("v%0d_error", i), int'(error), int'(vecs[i].code != 3'd0));
         check($sformatf("v%0d_balance", i), int'(balance), int'(vecs[i].bal));
         held_code = respCode;
         held_bal  = balance;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_pulse_end", i), int'(respValid), 0);
         check($sformatf("v%0d_ready_back", i), int'(reqReady), 1);
         check($sformatf("v%0d_code_held", i), int'(respCode), int'(held_code));
         check($sformatf("v%0d_bal_held", i), int'(balance), int'(held_bal));
      end

      // Reset during the destination scan aborts the transfer and reloads the table.
      issue(12'd2178, 4'd4, 12'd3000, 3'b110, 11'd100, lat);
      check("pre_abort_resp", lat, 12);
      @(posedge clk);
      #1;
      accNumber = 12'd2178; pin = 4'd4; destinationAccNumber = 12'd3000;
      menuOption = 3'b110; amount = 11'd100; reqValid = 1'b1;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_reqReady", int'(reqReady), 1);
      check("abort_respValid", int'(respValid), 0);
      pulses = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (respValid) pulses++;
      end
      check("abort_no_resp", pulses, 0);
      issue(12'd2178, 4'd4, 12'd0, 3'b011, 11'd0, lat);
      check("abort_bal_latency", lat, 2);
      check("abort_bal_code", int'(respCode), 0);
      check("abort_bal_value", int'(balance), 500);
      issue(12'd3000, 4'd1, 12'd0, 3'b011, 11'd0, lat);
      check("abort_dst_value", int'(balance), 2047);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/account_ledger.md
# account_ledger

Bank-side account store that answers transaction requests issued by the ATM session controller. Holds a fixed table of accounts (number, PIN, balance). Per request: sequentially scans the table, authenticates, applies balance, withdraw, deposit or transfer arithmetic, and returns one registered response with a status code. It is the responder end of the ATM core's account request interface.

## Interface
- `NUM_ACCOUNTS`, 10: table depth.
- `ACC_W`, 12: account number width.
- `PIN_W`, 4: PIN width.
- `BAL_W`, 11: balance and amount width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reqValid` in 1: request present.
- `reqReady` out 1: ledger can accept a request; high only in IDLE.
- `accNumber` in ACC_W: source account.
- `pin` in PIN_W: source PIN.
- `destinationAccNumber` in ACC_W: transfer target.
- `menuOption` in 3: opcode, uses the codebase menu encoding.
- `amount` in BAL_W: unsigned amount.
- `respValid` out 1: one-cycle response pulse.
- `respCode` out 3: status code.
- `error` out 1: `respCode != OK`.
- `balance` out BAL_W: source balance after the operation; 0 on any error.

## Operation
- Reset:
  - Table loads from package init constants.
  - State goes to IDLE, `reqReady=1`.
  - `respValid=0`, `respCode=OK`, `error=0`, `balance=0`.
- Accept: a request is accepted when `reqValid && reqReady` at a rising edge. All request fields are latched on that edge; later input changes are ignored.
- FSM states: IDLE, SCAN_SRC, SCAN_DST, EXEC, RESP.
- IDLE → SCAN_SRC on accept, with idx=0.
- SCAN_SRC: compares entry idx against the latched account once per edge.
  - Match: latch srcIdx.
    - Transfer goes to SCAN_DST with idx=0.
    - Any other op goes to EXEC.
  - Miss at idx=NUM_ACCOUNTS-1: code NOT_FOUND, go to RESP.
- SCAN_DST: same scan against destinationAccNumber. A miss at the last entry gives DEST_NOT_FOUND and goes to RESP.
- EXEC: checks are evaluated in this priority order, and the first failing check sets the code. The table is written only on OK.
  1. FIND (000): no PIN check, OK.
  2. Opcodes 001 and 010: BAD_OP.
  3. PIN mismatch: BAD_PIN.
  4. BALANCE (011): no change.
  5. WITHDRAW (100) and WITHDRAW_SHOW_BALANCE (101): if amount > bal then INSUFFICIENT; otherwise bal -= amount.
  6. DEPOSIT (111): if bal+amount > 2^BAL_W-1 then OVERFLOW; otherwise bal += amount.
  7. TRANSACTION (110):
     - srcIdx==dstIdx gives SAME_ACCOUNT.
     - amount > src bal gives INSUFFICIENT.
     - dst bal+amount overflow gives OVERFLOW.
     - Otherwise both entries update on the same edge.
- Width rule: the sum is computed BAL_W+1 wide and never wraps.
- RESP: `respValid=1` for exactly one cycle, then IDLE.
  - `respCode`, `error` and `balance` are registered.
  - They stay stable until the next response.
- Reset mid-operation: aborts the request. No response is issued, and the table reinitialises.
- Duplicate account numbers in the table: the lowest index wins.

## Timing
- The accept edge is edge 0. Source match at index s; destination match at index d.
- Non-transfer: `respValid` goes high after edge s+2.
- Transfer: `respValid` goes high after edge s+d+3.
- Source miss: `respValid` goes high after edge NUM_ACCOUNTS.
- Destination miss: `respValid` goes high after edge s+1+NUM_ACCOUNTS.
- `reqReady` is low from edge 0 until IDLE is re-entered, i.e. the edge after RESP. Back-to-back requests therefore have at least one IDLE cycle between them.
- Table writes occur on the EXEC→RESP edge.

## Structure
- Package `atm_pkg` holds:
  - Menu opcode constants, matching the existing define values.
  - Status codes: OK=0, NOT_FOUND=1, BAD_PIN=2, INSUFFICIENT=3, OVERFLOW=4, DEST_NOT_FOUND=5, SAME_ACCOUNT=6, BAD_OP=7.
  - The FSM state encoding.
  - Init arrays `ACC_INIT`, `PIN_INIT`, `BAL_INIT`.
- Sub-module `account_scanner`: index counter plus comparator. It is instanced once and reused for both the source and destination scans.
- Test table:
  - idx0: 2178 / PIN 4 / balance 500.
  - idx5: 2429 / PIN 9 / balance 1000.
  - idx9: 3000 / PIN 1 / balance 2047.

## Test plan
- Reset, then BALANCE (011) on 2178, PIN 4 → `respValid` after edge 2; OK, balance 500.
- WITHDRAW 200 on 2178 with PIN 4 → OK, balance 300. Then WITHDRAW 301 → INSUFFICIENT, error=1, balance 0, stored balance stays 300.
- DEPOSIT 1 on 3000, PIN 1 → OVERFLOW, stored balance stays 2047. DEPOSIT 0 → OK, balance 2047, `respValid` after edge 11.
- TRANSACTION 100 from 2178 (PIN 4) to 2429 → OK, balance 400 after edge 8. A following BALANCE on 2429 with PIN 9 → 1100.
- Account 1234 → NOT_FOUND after edge 10. 2178 with PIN 5 → BAD_PIN. Transfer 2178→2178 → SAME_ACCOUNT. Opcode 010 → BAD_OP.
- Assert `rst` during SCAN_DST of a transfer → no `respValid`, `reqReady=1` on the next cycle, 2178 balance back to 500.
